lsu_rmw: RTL and testbench

Load/store unit sitting between the CPU's MEM stage and `data_mem`. It initiates all data-memory traffic, accepting byte, halfword and word loads and stores through a ready/valid request handshake. It always drives `data_mem` with word-aligned, big-endian word accesses, and it implements sub-word stores as a read-modify-write sequence, because `data_mem` only writes whole words.

---
 rtl/lsu_rmw.sv | 159 +++++++++++++++
 tb/tb_lsu_rmw.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit: word-aligned big-endian data_mem traffic, sub-word stores via read-modify-write.
// Optional alignment trap: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module lsu_rmw (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        req_ready,
   input  logic        op_write,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        misaligned,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        mem_read,
   output logic        mem_write
);

   typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StErr} state_e;

   state_e      state_q;
   logic        op_write_q;
   logic [1:0]  size_q;
   logic        sign_ext_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        done_q;
   logic        misaligned_q;
   logic [31:0] mem_address_q;
   logic [31:0] mem_write_data_q;
   logic        mem_read_q;
   logic        mem_write_q;

   logic [1:0]  acc_off;
   logic        misalign_req;
   logic [4:0]  shamt;
   logic [31:0] lane_mask;
   logic [31:0] lane;
   logic [31:0] load_val;
   logic [31:0] merge;

   // Effective lane offset of the incoming request; misaligned low bits are dropped.
   always_comb begin
      acc_off      = addr[1:0];
      misalign_req = 1'b0;
      if (size == 2'b01) begin
         acc_off = {addr[1], 1'b0};
      end else if (size[1]) begin
         acc_off = 2'b00;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_req = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`endif
   end

   // Big-endian lane select: offset 0 is the most significant lane.
   always_comb begin
      shamt     = 5'd0;
      lane_mask = 32'hFFFF_FFFF;
      if (size_q == 2'b00) begin
         shamt     = {~off_q, 3'b000};
         lane_mask = 32'h0000_00FF << shamt;
      end else if (size_q == 2'b01) begin
         shamt     = {~off_q[1], 4'b0000};
         lane_mask = 32'h0000_FFFF << shamt;
      end
      lane     = (mem_read_data >> shamt) & (lane_mask >> shamt);
      load_val = lane;
      if (sign_ext_q) begin
         if ((size_q == 2'b00) && lane[7]) begin
            load_val = lane | 32'hFFFF_FF00;
         end else if ((size_q == 2'b01) && lane[15]) begin
            load_val = lane | 32'hFFFF_0000;
         end
      end
      merge = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         op_write_q       <= 1'b0;
         size_q           <= 2'b00;
         sign_ext_q       <= 1'b0;
         off_q            <= 2'b00;
         wdata_q          <= 32'h0;
         rdata_q          <= 32'h0;
         done_q           <= 1'b0;
         misaligned_q     <= 1'b0;
         mem_address_q    <= 32'h0;
         mem_write_data_q <= 32'h0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  op_write_q    <= op_write;
                  size_q        <= size;
                  sign_ext_q    <= sign_ext;
                  off_q         <= acc_off;
                  wdata_q       <= wdata;
                  mem_address_q <= {addr[31:2], 2'b00};
                  if (misalign_req) begin
                     done_q       <= 1'b1;
                     misaligned_q <= 1'b1;
                     state_q      <= StErr;
                  end else if (op_write && size[1]) begin
                     mem_write_data_q <= wdata;
                     mem_write_q      <= 1'b1;
                     state_q          <= StWr;
                  end else begin
                     mem_read_q <= 1'b1;
                     state_q    <= StRd;
                  end
               end
            end
            StRd: begin
               if (op_write_q) begin
                  mem_write_data_q <= merge;
                  mem_write_q      <= 1'b1;
                  state_q          <= StWr;
               end else begin
                  rdata_q <= load_val;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StWr: begin
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            StErr:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready      = (state_q == StIdle) && !rst;
   // A reset landing on the WR cycle must never reach memory.
   assign mem_write      = mem_write_q && !rst;
   assign mem_read       = mem_read_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign rdata          = rdata_q;
   assign done           = done_q;
   assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: directed plan steps then random accesses against a byte-level memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN the same way the design build does.
module tb_lsu_rmw;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        req_ready;
   logic        op_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        misaligned;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_read;
   logic        mem_write;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] exp_rdata;
   logic [31:0] last_rdata;
   int          vectors;
   int          miscompares;

   lsu_rmw dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_ready      (req_ready),
      .op_write       (op_write),
      .size           (size),
      .sign_ext       (sign_ext),
      .addr           (addr),
      .wdata          (wdata),
      .rdata          (rdata),
      .done           (done),
      .misaligned     (misaligned),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address[9:2]];

   always @(posedge clk) begin
      if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: memory as four big-endian bytes per word; size gives the byte count.
   task automatic model(input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic mis, output int nrd, output int nwr);
      int          n;
      int          off;
      logic [7:0]  b [4];
      logic [31:0] w;
      logic [31:0] v;
      logic [31:0] ones;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (off % n) != 0;
`else
      off = off - (off % n);
`endif
      if (mis) begin
         lat = 1; nrd = 0; nwr = 0;
         return;
      end
      w = ref_mem[a[9:2]];
      for (int i = 0; i < 4; i++) b[i] = 8'(w >> (24 - 8 * i));
      if (wr) begin
         for (int i = 0; i < n; i++) b[off + i] = 8'(wd >> (8 * (n - 1 - i)));
         ref_mem[a[9:2]] = {b[0], b[1], b[2], b[3]};
         nwr = 1;
         nrd = (n < 4) ? 1 : 0;
         lat = (n < 4) ? 3 : 2;
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(b[off + i]);
         ones = 32'hFFFF_FFFF;
         if (sx && (n < 4) && v[8 * n - 1]) v = v | (ones << (8 * n));
         exp_rdata = v;
         nrd = 1; nwr = 0; lat = 2;
      end
   endtask

   // Called on a negedge; returns on the negedge of the cycle after done.
   task automatic do_access(input logic wr, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd, input logic hold);
      int   e_lat, e_nrd, e_nwr;
      logic e_mis;
      int   lat, nrd, nwr, both, bad_addr, early_ready;
      logic o_mis;
      model(wr, sz, sx, a, wd, e_lat, e_mis, e_nrd, e_nwr);
      req = 1'b1; op_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
      check("ready_before_accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      lat = -1; nrd = 0; nwr = 0; both = 0; bad_addr = 0; early_ready = 0; o_mis = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (!hold) req = 1'b0;
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (mem_read && mem_write) both++;
         if ((mem_read || mem_write) && (mem_address !== {a[31:2], 2'b00})) bad_addr++;
         if (req_ready) early_ready++;
         if (done) begin
            lat = c; o_mis = misaligned; last_rdata = rdata;
            break;
         end
      end
      req = 1'b0;
      check("done_latency", 32'(lat), 32'(e_lat));
      check("misaligned", 32'(o_mis), 32'(e_mis));
      check("rdata", last_rdata, exp_rdata);
      check("read_strobes", 32'(nrd), 32'(e_nrd));
      check("write_strobes", 32'(nwr), 32'(e_nwr));
      check("strobe_overlap", 32'(both), 32'd0);
      check("strobe_address", 32'(bad_addr), 32'd0);
      check("ready_while_busy", 32'(early_ready), 32'd0);
      @(negedge clk);
      check("ready_after_done", 32'(req_ready), 32'd1);
      check("done_single_pulse", 32'(done), 32'd0);
      check("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);
   endtask

   initial begin
      vectors = 0; miscompares = 0; exp_rdata = 32'h0; last_rdata = 32'h0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0; ref_mem[i] = 32'h0;
      end
      mem[8'h40] = 32'h8844_2211; ref_mem[8'h40] = 32'h8844_2211;

      // Reset with a request pending: must not be accepted.
      rst = 1'b1; req = 1'b1; op_write = 1'b0; size = 2'b10; sign_ext = 1'b0;
      addr = 32'h100; wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_misaligned", 32'(misaligned), 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_write_data", mem_write_data, 32'h0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      rst = 1'b0; req = 1'b0;
      @(negedge clk);
      check("post_rst_idle_read", 32'(mem_read), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Plan steps 1-5.
      do_access(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 1'b0);
      check("t1_lb_sext", last_rdata, 32'hFFFF_FF88);
      do_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0);
      check("t2_lh_zext", last_rdata, 32'h0000_2211);
      do_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b0);
      check("t2_lh_sext_pos", last_rdata, 32'h0000_2211);
      do_access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1'b0);
      check("t2_lh_sext_neg", last_rdata, 32'hFFFF_8844);
      do_access(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, 1'b0);
      check("t3_sb_mem", mem[8'h40], 32'h88AB_2211);
      do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0);
      check("t3_lw_after_sb", last_rdata, 32'h88AB_2211);
      do_access(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 1'b1);
      check("t4_sw_mem", mem[8'h41], 32'hDEAD_BEEF);
      do_access(1'b1, 2'b10, 1'b0, 32'h100, 32'h8844_2211, 1'b0);
      do_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("t5_lw_mis_rdata_held", last_rdata, 32'h88AB_2211);
`else
      check("t5_lw_forced_align", last_rdata, 32'h8844_2211);
`endif

      // Step 6: reset during the WR cycle of a halfword store.
      req = 1'b1; op_write = 1'b1; size = 2'b01; sign_ext = 1'b0;
      addr = 32'h100; wdata = 32'h0000_1234;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("t6_rd_cycle", 32'(mem_read), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t6_write_gated", 32'(mem_write), 32'd0);
      check("t6_no_done_wr", 32'(done), 32'd0);
      check("t6_ready_in_rst", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_ready_after_rst", 32'(req_ready), 32'd1);
      check("t6_no_done_after", 32'(done), 32'd0);
      check("t6_mem_intact", mem[8'h40], 32'h8844_2211);
      exp_rdata = 32'h0;
      check("t6_rdata_reset", rdata, 32'h0);

      // Random accesses over a few words, upper address bits randomised.
      for (int k = 0; k < 150; k++) begin
         logic [31:0] ra;
         ra = $urandom;
         ra[9:4] = 6'd0;
         do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
